data_ram_bank: RTL and testbench

//  Parametrised, synchronous, byte-enabled data memory for the MEM stage of the MIPS core.

---
 rtl/data_ram_bank.sv | 158 +++++++++++++++
 tb/tb_data_ram_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_ram_bank
// Purpose  : Single-port, byte-enabled data memory for the MEM stage.
//            Optional post-reset zero fill, READ_LAT of 1 or 2, and an
//            out-of-range error response.
// Revision : 1.0 - initial release
// ============================================================================
module data_ram_bank #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 4096,
  parameter int READ_LAT       = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [31:0]         addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                ready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                rvalid_o,
  output logic                err_o
);

  localparam int NB  = DATA_W / 8;
  localparam int AW  = $clog2(DEPTH);
  localparam int OFS = $clog2(NB);
  localparam int HI  = AW + OFS;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_t          state_q, state_d;
  logic [AW-1:0]   fill_q, fill_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              w_fill;
  logic              w_accept;
  logic              w_oor;
  logic              w_wr;
  logic              w_rd;
  logic [AW-1:0]     w_idx;
  logic [AW-1:0]     w_mem_idx;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [NB-1:0]     w_lane_we;
  logic              w_unused_lo;

  // Stage-1 response registers (valid, error, data) and write-error pulse
  logic              rv1_q, rerr1_q, werr_q;
  logic [DATA_W-1:0] rdat1_q;

  // Ready is forced low while reset is asserted, even when no fill is configured
  assign ready_o  = (state_q == ST_RUN) & rst_n;
  assign w_fill   = (state_q == ST_INIT);
  assign w_accept = ce_i & ready_o;
  assign w_oor    = |addr_i[31:HI];
  assign w_idx    = addr_i[HI-1:OFS];
  assign w_wr     = w_accept & we_i & ~w_oor;
  assign w_rd     = w_accept & ~we_i;

  // Byte-offset bits never select anything; lanes come from sel_i only
  assign w_unused_lo = ^addr_i[OFS-1:0];

  // Fill and normal writes share the single array port
  assign w_mem_idx   = w_fill ? fill_q : w_idx;
  assign w_mem_wdata = w_fill ? '0 : wdata_i;
  assign w_lane_we   = w_fill ? {NB{1'b1}} : (sel_i & {NB{w_wr}});

  // State and fill counter; reset restarts any fill from word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Next state: walk the fill counter through every word, then run
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      ST_INIT: begin
        fill_d = fill_q + AW'(1);
        if (fill_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
          fill_d  = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Array write port with per-byte enables; the array itself is never reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (w_lane_we[i]) begin
        mem_q[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end

  // First response stage; data is held at zero unless a good read is returning
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv1_q   <= 1'b0;
      rerr1_q <= 1'b0;
      rdat1_q <= '0;
      werr_q  <= 1'b0;
    end else begin
      rv1_q   <= w_rd;
      rerr1_q <= w_rd & w_oor;
      rdat1_q <= (w_rd && !w_oor) ? mem_q[w_idx] : '0;
      werr_q  <= w_accept & we_i & w_oor;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              rv2_q, rerr2_q;
    logic [DATA_W-1:0] rdat2_q;

    // Extra output register stage for the two-cycle read path
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rv2_q   <= 1'b0;
        rerr2_q <= 1'b0;
        rdat2_q <= '0;
      end else begin
        rv2_q   <= rv1_q;
        rerr2_q <= rerr1_q;
        rdat2_q <= rdat1_q;
      end
    end

    assign rvalid_o = rv2_q;
    assign rdata_o  = rdat2_q;
    assign err_o    = rerr2_q | werr_q;
  end else begin : g_lat1
    assign rvalid_o = rv1_q;
    assign rdata_o  = rdat1_q;
    assign err_o    = rerr1_q | werr_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_data_ram_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_bank
// Purpose  : Self-checking bench for data_ram_bank. Three instances:
//            a = 16 words, 1-cycle read, fill on reset
//            b = 4096 words, 2-cycle read, fill on reset
//            c = 16 words, 1-cycle read, no fill
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_ram_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdata;
  int          dsel;

  logic        ce_a, ce_b, ce_c;
  logic        ready_a, ready_b, ready_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        err_a, err_b, err_c;
  logic [31:0] rdata_a, rdata_b, rdata_c;

  int nchk = 0;
  int nerr = 0;

  assign ce_a = ce & (dsel == 0);
  assign ce_b = ce & (dsel == 1);
  assign ce_c = ce & (dsel == 2);

  always #5 clk = ~clk;

  data_ram_bank #(.DATA_W(32), .DEPTH(16), .READ_LAT(1), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .ce_i(ce_a), .we_i(we), .sel_i(sel), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready_a), .rdata_o(rdata_a), .rvalid_o(rvalid_a), .err_o(err_a));

  data_ram_bank #(.DATA_W(32), .DEPTH(4096), .READ_LAT(2), .CLEAR_ON_RESET(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ce_i(ce_b), .we_i(we), .sel_i(sel), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready_b), .rdata_o(rdata_b), .rvalid_o(rvalid_b), .err_o(err_b));

  data_ram_bank #(.DATA_W(32), .DEPTH(16), .READ_LAT(1), .CLEAR_ON_RESET(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .ce_i(ce_c), .we_i(we), .sel_i(sel), .addr_i(addr),
    .wdata_i(wdata), .ready_o(ready_c), .rdata_o(rdata_c), .rvalid_o(rvalid_c), .err_o(err_c));

  typedef struct {
    int          d;
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_rv;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic get(input int d, output logic rv, output logic er,
                     output logic [31:0] rd, output logic rdy);
    case (d)
      0:       begin rv = rvalid_a; er = err_a; rd = rdata_a; rdy = ready_a; end
      1:       begin rv = rvalid_b; er = err_b; rd = rdata_b; rdy = ready_b; end
      default: begin rv = rvalid_c; er = err_c; rd = rdata_c; rdy = ready_c; end
    endcase
  endtask

  function automatic int lat_of(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  // One request, then sample the response point (write: +1 cycle, read: +READ_LAT)
  task automatic do_vec(input vec_t v, input string nm);
    logic rv, er, rdy;
    logic [31:0] rd;
    int lat;
    @(negedge clk);
    dsel = v.d; ce = 1'b1; we = v.w; sel = v.s; addr = v.a; wdata = v.wd;
    @(posedge clk);
    #1 ce = 1'b0;
    lat = v.w ? 1 : lat_of(v.d);
    repeat (lat - 1) @(posedge clk);
    @(negedge clk);
    get(v.d, rv, er, rd, rdy);
    chk({nm, "_rvalid"}, {31'b0, rv}, {31'b0, v.exp_rv});
    chk({nm, "_err"},    {31'b0, er}, {31'b0, v.exp_err});
    chk({nm, "_rdata"},  rd, v.exp_rd);
  endtask

  // Counts edges from now until the given instance is ready; bounded
  task automatic wait_ready(input int d, input int start, output int n);
    logic rv, er, rdy;
    logic [31:0] rd;
    n = start;
    get(d, rv, er, rd, rdy);
    while (!rdy && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
      get(d, rv, er, rd, rdy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   n, nb;
    logic seen;
    logic [31:0] exp_pipe_rd [5];
    logic        exp_pipe_rv [5];

    tbl[0]  = '{1, 1'b1, 4'hF, 32'h40,       32'hAABBCCDD, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1, 1'b1, 4'h5, 32'h40,       32'h11223344, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1, 1'b0, 4'h0, 32'h40,       32'h0,        1'b1, 1'b0, 32'hAA22CC44};
    tbl[3]  = '{1, 1'b0, 4'h0, 32'h4000,     32'h0,        1'b1, 1'b1, 32'h0};
    tbl[4]  = '{1, 1'b1, 4'hF, 32'h4000,     32'h1,        1'b0, 1'b1, 32'h0};
    tbl[5]  = '{1, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0};
    tbl[6]  = '{1, 1'b1, 4'h0, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0};
    tbl[8]  = '{1, 1'b1, 4'h3, 32'h44,       32'h55667788, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1, 1'b0, 4'h0, 32'h44,       32'h0,        1'b1, 1'b0, 32'h00007788};
    tbl[10] = '{1, 1'b0, 4'h0, 32'h80000000, 32'h0,        1'b1, 1'b1, 32'h0};
    tbl[11] = '{0, 1'b1, 4'hF, 32'h3C,       32'h12345678, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{0, 1'b0, 4'h0, 32'h3D,       32'h0,        1'b1, 1'b0, 32'h12345678};
    tbl[13] = '{0, 1'b0, 4'h0, 32'h40,       32'h0,        1'b1, 1'b1, 32'h0};
    tbl[14] = '{0, 1'b1, 4'h8, 32'h8,        32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    tbl[15] = '{0, 1'b0, 4'h0, 32'h8,        32'h0,        1'b1, 1'b0, 32'hCA000000};
    tbl[16] = '{2, 1'b1, 4'hF, 32'h4,        32'h01020304, 1'b0, 1'b0, 32'h0};
    tbl[17] = '{2, 1'b0, 4'h0, 32'h4,        32'h0,        1'b1, 1'b0, 32'h01020304};
    tbl[18] = '{1, 1'b1, 4'hF, 32'h0,        32'h0A0A0A0A, 1'b0, 1'b0, 32'h0};
    tbl[19] = '{1, 1'b1, 4'hF, 32'h4,        32'h0B0B0B0B, 1'b0, 1'b0, 32'h0};
    tbl[20] = '{1, 1'b1, 4'hF, 32'h8,        32'h0C0C0C0C, 1'b0, 1'b0, 32'h0};

    rst_n = 1'b0; ce = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'h0; wdata = 32'h0; dsel = 0;

    // ---- Reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_a",  {31'b0, ready_a},  32'h0);
    chk("rst_ready_b",  {31'b0, ready_b},  32'h0);
    chk("rst_ready_c",  {31'b0, ready_c},  32'h0);
    chk("rst_rvalid_a", {31'b0, rvalid_a}, 32'h0);
    chk("rst_err_b",    {31'b0, err_b},    32'h0);
    chk("rst_rdata_b",  rdata_b,           32'h0);

    // ---- Reset fill; a write held on ce during INIT must be ignored ----
    dsel = 0; ce = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h0; wdata = 32'hFFFFFFFF;
    rst_n = 1'b1;
    #1;
    chk("nofill_ready_c", {31'b0, ready_c}, 32'h1);
    n = 0; seen = 1'b0;
    while (!ready_a && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (rvalid_a || err_a || rvalid_b || err_b) seen = 1'b1;
    end
    ce = 1'b0;
    chk("fill_cycles_a", n, 16);
    chk("init_no_resp", {31'b0, seen}, 32'h0);
    wait_ready(1, n, nb);
    chk("fill_cycles_b", nb, 4096);

    for (int k = 0; k < 16; k++)
      do_vec('{0, 1'b0, 4'h0, 32'(k * 4), 32'h0, 1'b1, 1'b0, 32'h0}, $sformatf("fill_word%0d", k));

    // ---- Table of single transactions ----
    for (int i = 0; i < 21; i++)
      do_vec(tbl[i], $sformatf("vec%0d", i));

    // ---- Back-to-back reads on the 2-cycle instance ----
    exp_pipe_rv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_pipe_rd = '{32'h0, 32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0};
    @(negedge clk);
    dsel = 1; ce = 1'b1; we = 1'b0; addr = 32'h0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("pipe%0d_rvalid", k), {31'b0, rvalid_b}, {31'b0, exp_pipe_rv[k]});
      chk($sformatf("pipe%0d_rdata", k), rdata_b, exp_pipe_rd[k]);
      if (k < 2) addr = 32'((k + 1) * 4);
      else       ce = 1'b0;
    end

    // ---- Read immediately after write, both latencies ----
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      dsel = d; ce = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h10; wdata = 32'hDEADBEEF;
      @(negedge clk);
      we = 1'b0;
      @(posedge clk);
      #1 ce = 1'b0;
      repeat (lat_of(d) - 1) @(posedge clk);
      @(negedge clk);
      if (d == 0) begin
        chk("raw_a_rvalid", {31'b0, rvalid_a}, 32'h1);
        chk("raw_a_rdata",  rdata_a, 32'hDEADBEEF);
      end else begin
        chk("raw_b_rvalid", {31'b0, rvalid_b}, 32'h1);
        chk("raw_b_rdata",  rdata_b, 32'hDEADBEEF);
      end
    end

    // ---- Reset during an in-flight read (b) ----
    do_vec('{0, 1'b1, 4'hF, 32'h30, 32'h11111111, 1'b0, 1'b0, 32'h0}, "pre_rst_wr");
    @(negedge clk);
    dsel = 1; ce = 1'b1; we = 1'b0; addr = 32'h40;
    @(posedge clk);
    #1 ce = 1'b0;
    #1 rst_n = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    chk("inflight_rst_ready_b", {31'b0, ready_b}, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rvalid_b || err_b) seen = 1'b1;
    end
    chk("inflight_flushed", {31'b0, seen}, 32'h0);

    // ---- Reset during INIT at word 7 (a): fill must restart from 0 ----
    // Four edges have passed since release; three more put a at word 7
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midinit_ready_a", {31'b0, ready_a}, 32'h0);
    rst_n = 1'b1;
    wait_ready(0, 0, n);
    chk("refill_cycles_a", n, 16);
    wait_ready(1, n, nb);
    chk("refill_cycles_b", nb, 4096);
    do_vec('{0, 1'b0, 4'h0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h0}, "refill_word12");
    do_vec('{1, 1'b0, 4'h0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h0}, "refill_b_0x40");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
